seq_detect_param: RTL

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 118 +++++++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
//   Serial pattern detector with a run-time loadable pattern, optional
//   overlapping detection and a saturating match counter.
//
//   Incoming valid bits shift into a PAT_W-bit history register, entering
//   at the LSB. A fill counter tracks how many valid bits have arrived since
//   the last restart. A match requires a full window (fill == PAT_W) whose
//   contents equal the active pattern. Restarts happen on reset, on a
//   pattern load, and after a non-overlapping match.
//
//   Handshake: datain is consumed on a rising clock edge only when din_valid
//   is 1 and pat_load is 0. There is no back-pressure; every such edge
//   consumes exactly one bit.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   datain       in   serial data bit
//   din_valid    in   datain qualifier
//   overlap_en   in   1 = overlapping detection, 0 = non-overlapping
//   pat_load     in   load pat_in as the active pattern (restarts the window)
//   pat_in       in   [PAT_W-1:0] new pattern, bit PAT_W-1 is received first
//   clr_count    in   synchronous clear of match_count
//   dataout      out  one-cycle registered match pulse
//   match_count  out  [CNT_W-1:0] saturating match count
//   pattern      out  [PAT_W-1:0] active pattern register
// ---------------------------------------------------------------------------
module seq_detect_param #(
    parameter int                PAT_W     = 5,
    parameter logic [PAT_W-1:0]  PAT_RESET = 5'b11101,
    parameter int                CNT_W     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             datain,
    input  logic             din_valid,
    input  logic             overlap_en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             clr_count,
    output logic             dataout,
    output logic [CNT_W-1:0] match_count,
    output logic [PAT_W-1:0] pattern
);

    // Fill must be able to hold the value PAT_W itself.
    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              dout_q, dout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [PAT_W-1:0]  hist_shifted;
    logic [FILL_W-1:0] fill_inc;
    logic              match;

    always_comb begin
        hist_shifted = {hist_q[PAT_W-2:0], datain};
        fill_inc     = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

        hist_d = hist_q;
        pat_d  = pat_q;
        fill_d = fill_q;
        match  = 1'b0;

        if (pat_load) begin
            // Load wins over data: the incoming bit is dropped and the
            // window restarts so no pre-load bit can contribute.
            pat_d  = pat_in;
            fill_d = '0;
        end else if (din_valid) begin
            hist_d = hist_shifted;
            fill_d = fill_inc;
            if ((fill_inc == FILL_FULL) && (hist_shifted == pat_q)) begin
                match = 1'b1;
                // Overlapping keeps the full window so the very next bit can
                // complete another match; non-overlapping starts over.
                fill_d = overlap_en ? FILL_FULL : '0;
            end
        end

        dout_d = match;

        // Clear has priority over an increment on the same edge.
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            pat_q  <= PAT_RESET;
            fill_q <= '0;
            dout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            pat_q  <= pat_d;
            fill_q <= fill_d;
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dataout     = dout_q;
    assign match_count = cnt_q;
    assign pattern     = pat_q;

endmodule
